// File: rtl/width_16to8.sv
// 16-bit word to 8-bit byte re-serialiser (high byte first) with a word FIFO for downstream backpressure.
// Define WIDTH_16TO8_PARITY_EN to add an even-parity output registered alongside data_out.
module width_16to8 #(
  parameter int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [15:0]      data_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [7:0]       data_out,
  output logic             overflow,
`ifdef WIDTH_16TO8_PARITY_EN
  output logic             parity_out,
`endif
  output logic [LVL_W-1:0] level,
  output logic [1:0]       state_dbg
);

  // Output handshake: a byte moves on a rising edge where valid_out && ready_in;
  // while valid_out is high and ready_in is low, valid_out and data_out hold.
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [15:0]      rd_word;
  logic [7:0]       lo_q, lo_d, data_d;
  logic             valid_d, pop, push, full, has_word, xfer;

  assign full      = (level == LVL_W'(DEPTH));
  assign has_word  = (level != '0);
  assign rd_word   = mem[rd_ptr];
  assign xfer      = valid_out && ready_in;
  // A full FIFO still accepts a word when the serialiser frees a slot this cycle.
  assign push      = valid_in && (!full || pop);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    valid_d = valid_out;
    data_d  = data_out;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (has_word) begin
          pop     = 1'b1;
          data_d  = rd_word[15:8];
          lo_d    = rd_word[7:0];
          valid_d = 1'b1;
          state_d = HI;
        end
      end
      HI: begin
        if (xfer) begin
          data_d  = lo_q;
          state_d = LO;
        end
      end
      LO: begin
        if (xfer) begin
          if (has_word) begin
            pop     = 1'b1;
            data_d  = rd_word[15:8];
            lo_d    = rd_word[7:0];
            state_d = HI;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      valid_out  <= 1'b0;
      data_out   <= 8'h00;
      lo_q       <= 8'h00;
`ifdef WIDTH_16TO8_PARITY_EN
      parity_out <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      valid_out <= valid_d;
      data_out  <= data_d;
      lo_q      <= lo_d;
`ifdef WIDTH_16TO8_PARITY_EN
      parity_out <= ^data_d;
`endif
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
      if (valid_in && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_width_16to8.sv
// Bench for width_16to8: queue-based byte-stream model checked every cycle, plus directed literal checks.
module tb_width_16to8;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             valid_in = 1'b0;
  logic [15:0]      data_in = 16'h0000;
  logic             ready_in = 1'b0;
  logic             valid_out;
  logic [7:0]       data_out;
  logic             overflow;
  logic [LVL_W-1:0] level;
  logic [1:0]       state_dbg;
`ifdef WIDTH_16TO8_PARITY_EN
  logic             parity_out;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int max_level = 0;

  // Model: words waiting in the FIFO, and bytes still owed by the serialiser.
  logic [15:0] m_fifo[$];
  logic [7:0]  exp_q[$];
  bit          m_ovf = 1'b0;
  logic [7:0]  got_q[$];
  int          got_cyc[$];
  logic [7:0]  exp_s[$];

  width_16to8 #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid_in(valid_in),
    .data_in(data_in),
    .ready_in(ready_in),
    .valid_out(valid_out),
    .data_out(data_out),
    .overflow(overflow),
`ifdef WIDTH_16TO8_PARITY_EN
    .parity_out(parity_out),
`endif
    .level(level),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  always @(negedge clk) begin
    bit          xfer_m;
    bit          need;
    bit          full_m;
    logic [15:0] w;
    if (!rst_n) begin
      m_fifo.delete();
      exp_q.delete();
      m_ovf = 1'b0;
    end
    chk("valid_out", valid_out, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("data_out", data_out, exp_q[0]);
`ifdef WIDTH_16TO8_PARITY_EN
      chk("parity_out", parity_out, ^exp_q[0]);
`endif
    end
    chk("level", level, m_fifo.size());
    chk("overflow", overflow, m_ovf);
    if (int'(level) > max_level) max_level = int'(level);
    if (rst_n) begin
      xfer_m = (exp_q.size() != 0) && ready_in;
      if (xfer_m) begin
        got_q.push_back(data_out);
        got_cyc.push_back(cyc);
        void'(exp_q.pop_front());
      end
      need   = (exp_q.size() == 0) && (m_fifo.size() != 0);
      full_m = (m_fifo.size() == DEPTH);
      if (need) begin
        w = m_fifo.pop_front();
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
      end
      if (valid_in) begin
        if (!full_m || need) m_fifo.push_back(data_in);
        else m_ovf = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
    max_level = 0;
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_log();
  endtask

  task automatic push_seq(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      data_in  = base + 16'(i);
      tick();
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      tick();
      n++;
      done = (exp_q.size() == 0) && (m_fifo.size() == 0) && !valid_out;
    end
    chk({name, "_drain"}, done, 1'b1);
  endtask

  task automatic chk_stream(input string name, input logic [7:0] exp_b[$]);
    chk({name, "_count"}, got_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_q.size(); i++)
      chk(name, got_q[i], exp_b[i]);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("reset_valid", valid_out, 1'b0);
    chk("reset_data", data_out, 8'h00);
    chk("reset_level", level, 0);
    chk("reset_ovf", overflow, 1'b0);
    chk("reset_state", state_dbg, 2'd0);
    rst_n    = 1'b1;
    ready_in = 1'b1;
    tick();
    clear_log();

    // single word latency
    valid_in = 1'b1;
    data_in  = 16'hA55A;
    tick();
    valid_in = 1'b0;
    chk("sw_c1_valid", valid_out, 1'b0);
    chk("sw_c1_level", level, 1);
    tick();
    chk("sw_c2_valid", valid_out, 1'b1);
    chk("sw_c2_data", data_out, 8'hA5);
    tick();
    chk("sw_c3_valid", valid_out, 1'b1);
    chk("sw_c3_data", data_out, 8'h5A);
    tick();
    chk("sw_c4_valid", valid_out, 1'b0);
    chk("sw_c4_level", level, 0);
    chk("sw_c4_ovf", overflow, 1'b0);

    // back-to-back stream at one word per 2 cycles
    reset_dut();
    push_seq(16'h0102, 1); tick();
    push_seq(16'h0304, 1); tick();
    push_seq(16'h0506, 1);
    wait_drain("b2b");
    exp_s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    chk_stream("b2b_bytes", exp_s);
    for (int i = 1; i < got_cyc.size(); i++)
      chk("b2b_no_gap", got_cyc[i] - got_cyc[0], i);
    chk("b2b_level_max", max_level <= 1, 1'b1);

    // backpressure hold
    reset_dut();
    ready_in = 1'b0;
    push_seq(16'h1122, 1);
    for (int i = 0; i < 10 && !valid_out; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", valid_out, 1'b1);
      chk("bp_hold_data", data_out, 8'h11);
      tick();
    end
    ready_in = 1'b1;
    wait_drain("bp");
    exp_s = '{8'h11, 8'h22};
    chk_stream("bp_bytes", exp_s);

    // overflow with six words into DEPTH=4
    reset_dut();
    ready_in = 1'b0;
    push_seq(16'h1000, 6);
    tick();
    chk("ovf_level", level, 4);
    chk("ovf_flag", overflow, 1'b1);
    ready_in = 1'b1;
    wait_drain("ovf");
    exp_s = '{8'h10, 8'h00, 8'h10, 8'h01, 8'h10, 8'h02, 8'h10, 8'h03, 8'h10, 8'h04};
    chk_stream("ovf_bytes", exp_s);
    chk("ovf_sticky", overflow, 1'b1);

    // push while full, with a pop in the same cycle
    reset_dut();
    ready_in = 1'b0;
    push_seq(16'h2000, 5);
    tick();
    chk("pf_level_full", level, 4);
    chk("pf_hi_data", data_out, 8'h20);
    ready_in = 1'b1;
    tick();
    chk("pf_lo_data", data_out, 8'h00);
    valid_in = 1'b1;
    data_in  = 16'hBEEF;
    tick();
    valid_in = 1'b0;
    ready_in = 1'b0;
    chk("pf_level_kept", level, 4);
    chk("pf_ovf_clear", overflow, 1'b0);
    chk("pf_next_hi", data_out, 8'h20);
    ready_in = 1'b1;
    wait_drain("pf");
    exp_s = '{8'h20, 8'h00, 8'h20, 8'h01, 8'h20, 8'h02, 8'h20, 8'h03, 8'h20, 8'h04, 8'hBE, 8'hEF};
    chk_stream("pf_bytes", exp_s);

    // asynchronous reset while serialising the low byte
    reset_dut();
    ready_in = 1'b0;
    push_seq(16'h3000, 4);
    tick();
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    chk("rst_pre_level", level, 3);
    chk("rst_pre_lo", data_out, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", valid_out, 1'b0);
    chk("rst_async_level", level, 0);
    chk("rst_async_ovf", overflow, 1'b0);
    tick();
    tick();
    rst_n    = 1'b1;
    ready_in = 1'b1;
    clear_log();
    repeat (6) tick();
    chk("rst_no_stale", got_q.size(), 0);
    chk("rst_idle_valid", valid_out, 1'b0);

`ifdef WIDTH_16TO8_PARITY_EN
    reset_dut();
    push_seq(16'h0703, 1);
    tick();
    chk("par_hi_data", data_out, 8'h07);
    chk("par_hi", parity_out, 1'b1);
    tick();
    chk("par_lo_data", data_out, 8'h03);
    chk("par_lo", parity_out, 1'b0);
    wait_drain("par");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
